// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
// Nibble width and FSM state encoding.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_4_bit_adder.sv
// Combinational 4-bit ripple-carry adder.
// S = A + B + C0 (low 4 bits), C4 = carry out.
module ripple_carry_4_bit_adder (
    output logic [3:0] S,
    output logic       C4,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = C0;
        for (int i = 0; i < 4; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C4 = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit ripple adder per nibble.
// Operands handed in and results handed out over valid/ready.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q, sum_q;
    logic                 carry_q, cout_q;
    logic [IW-1:0]        idx_q;
    logic                 last;
    logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_s;
    logic                 nib_c4;

    assign last  = (idx_q == IW'(NIB - 1));
    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    ripple_carry_4_bit_adder u_rca (
        .S  (nib_s),
        .C4 (nib_c4),
        .A  (nib_a),
        .B  (nib_b),
        .C0 (carry_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_s;
                    carry_q <= nib_c4;
                    idx_q   <= last ? '0 : idx_q + 1'b1;
                    // cout latched from the final nibble so it stays put in DONE
                    if (last) cout_q <= nib_c4;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
